// File: rtl/bp_be_ptw_pte_responder_if.sv
// Walker-side load port, flush and backing-memory port of the PTW PTE responder.
// slave = responder view, master = walker/memory view.
interface bp_be_ptw_pte_responder_if #(
  parameter int paddr_width_p      = 40,
  parameter int ptag_width_p       = 28,
  parameter int dcache_pkt_width_p = 86,
  parameter int dpath_width_p      = 64
);
  logic                          dcache_v_i;
  logic [dcache_pkt_width_p-1:0] dcache_pkt_i;
  logic                          dcache_rdy_o;
  logic [ptag_width_p-1:0]       dcache_ptag_i;
  logic                          dcache_ptag_v_i;
  logic                          dcache_v_o;
  logic [dpath_width_p-1:0]      dcache_data_o;
  logic                          flush_i;

  logic                          mem_v_o;
  logic [paddr_width_p-1:0]      mem_addr_o;
  logic                          mem_ready_i;
  logic                          mem_v_i;
  logic [63:0]                   mem_data_i;

  modport slave (
    input  dcache_v_i, dcache_pkt_i, dcache_ptag_i, dcache_ptag_v_i, flush_i,
           mem_ready_i, mem_v_i, mem_data_i,
    output dcache_rdy_o, dcache_v_o, dcache_data_o, mem_v_o, mem_addr_o
  );

  modport master (
    output dcache_v_i, dcache_pkt_i, dcache_ptag_i, dcache_ptag_v_i, flush_i,
           mem_ready_i, mem_v_i, mem_data_i,
    input  dcache_rdy_o, dcache_v_o, dcache_data_o, mem_v_o, mem_addr_o
  );
endinterface

// File: rtl/bp_be_ptw_pte_responder.sv
// PTW PTE responder: fully-associative PTE buffer; hit data returned combinationally with the ptag, one cycle after accept.
// Backpressure: rdy low in stage 1, while a miss is pending and during flush; BP_BE_PTW_PTE_RESPONDER_PERF_EN adds hit/miss counters.
module bp_be_ptw_pte_responder #(
  parameter int paddr_width_p = 40,
  parameter int ptag_width_p  = 28,
  parameter int entries_p     = 4,
  parameter int dpath_width_p = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_be_ptw_pte_responder_if.slave bus
`ifdef BP_BE_PTW_PTE_RESPONDER_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int lg_entries_lp       = (entries_p > 1) ? $clog2(entries_p) : 1;
  localparam int dword_addr_width_lp = paddr_width_p - 3;
  localparam int opcode_width_lp     = 5;
  localparam int pkt_width_lp        = opcode_width_lp + 12 + 64 + 5;

  localparam logic [opcode_width_lp-1:0] e_dcache_op_ld = 5'd3;

  localparam logic [1:0] e_ready     = 2'd0;
  localparam logic [1:0] e_miss_req  = 2'd1;
  localparam logic [1:0] e_miss_wait = 2'd2;

  // Packet layout, MSB first: opcode, page_offset[11:0], data[63:0], rd_addr[4:0].
  logic [opcode_width_lp-1:0] pkt_opcode;
  logic [11:0]                pkt_page_offset;
  logic                       unused_pkt;

  assign pkt_opcode      = bus.dcache_pkt_i[pkt_width_lp-1 -: opcode_width_lp];
  assign pkt_page_offset = bus.dcache_pkt_i[pkt_width_lp-opcode_width_lp-1 -: 12];
  assign unused_pkt      = ^{bus.dcache_pkt_i[68:0], pkt_page_offset[2:0]};

  logic [1:0]                     state_r, state_n;
  logic                           s1_v_r;
  logic [8:0]                     s1_dword_offset_r;
  logic                           poison_r, poison_n;
  logic [dword_addr_width_lp-1:0] miss_addr_r;
  logic [lg_entries_lp-1:0]       victim_r;

  logic [entries_p-1:0]                          valid_r;
  logic [entries_p-1:0][dword_addr_width_lp-1:0] tag_r;
  logic [entries_p-1:0][63:0]                    data_r;

  logic                           accept;
  logic [dword_addr_width_lp-1:0] s2_dword;
  logic                           s2_lookup, s2_hit, s2_miss;
  logic [entries_p-1:0]           lookup_hit_v, fill_hit_v;
  logic [lg_entries_lp-1:0]       hit_idx, fill_hit_idx, inv_idx, fill_idx;
  logic [63:0]                    hit_data;
  logic                           fill_v, fill_we, victim_adv;

  assign bus.dcache_rdy_o = reset_n_i & (state_r == e_ready) & ~s1_v_r & ~bus.flush_i;
  assign accept = bus.dcache_v_i & bus.dcache_rdy_o & (pkt_opcode == e_dcache_op_ld);

  // Bits [2:0] of the page offset never reach the compare: the buffer holds whole dwords.
  assign s2_dword  = {bus.dcache_ptag_i, s1_dword_offset_r};
  assign s2_lookup = s1_v_r & bus.dcache_ptag_v_i;

  always_comb begin
    lookup_hit_v = '0;
    fill_hit_v   = '0;
    for (int i = 0; i < entries_p; i++) begin
      lookup_hit_v[i] = valid_r[i] & (tag_r[i] == s2_dword);
      fill_hit_v[i]   = valid_r[i] & (tag_r[i] == miss_addr_r);
    end
  end

  // Descending scan so the lowest matching / invalid index wins.
  always_comb begin
    hit_idx      = '0;
    fill_hit_idx = '0;
    inv_idx      = '0;
    for (int i = entries_p - 1; i >= 0; i--) begin
      if (lookup_hit_v[i]) hit_idx      = lg_entries_lp'(i);
      if (fill_hit_v[i])   fill_hit_idx = lg_entries_lp'(i);
      if (!valid_r[i])     inv_idx      = lg_entries_lp'(i);
    end
  end

  assign hit_data = data_r[hit_idx];
  assign s2_hit   = s2_lookup & (|lookup_hit_v) & ~bus.flush_i;
  assign s2_miss  = s2_lookup & ~(|lookup_hit_v);

  assign bus.dcache_v_o    = s2_hit;
  assign bus.dcache_data_o = s2_hit ? dpath_width_p'(hit_data) : '0;

  assign bus.mem_v_o    = (state_r == e_miss_req);
  assign bus.mem_addr_o = {miss_addr_r, 3'b000};

  assign fill_v  = (state_r == e_miss_wait) & bus.mem_v_i;
  assign fill_we = fill_v & ~poison_r & ~bus.flush_i;

  // An existing copy of the address is overwritten rather than duplicated.
  always_comb begin
    fill_idx   = victim_r;
    victim_adv = 1'b0;
    if (|fill_hit_v) begin
      fill_idx = fill_hit_idx;
    end else if (!(&valid_r)) begin
      fill_idx = inv_idx;
    end else begin
      victim_adv = fill_we;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready:     if (s2_miss)         state_n = e_miss_req;
      e_miss_req:  if (bus.mem_ready_i) state_n = e_miss_wait;
      e_miss_wait: if (bus.mem_v_i)     state_n = e_ready;
      default:                          state_n = e_ready;
    endcase
  end

  // A flush while a miss is in flight makes the returning dword stale.
  always_comb begin
    poison_n = poison_r;
    if (bus.flush_i && (state_r != e_ready)) poison_n = 1'b1;
    if (fill_v)                              poison_n = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r           <= e_ready;
      s1_v_r            <= 1'b0;
      s1_dword_offset_r <= '0;
      poison_r          <= 1'b0;
      miss_addr_r       <= '0;
      victim_r          <= '0;
    end else begin
      state_r  <= state_n;
      poison_r <= poison_n;
      s1_v_r   <= accept;
      if (accept) s1_dword_offset_r <= pkt_page_offset[11:3];
      if (s2_miss) miss_addr_r <= s2_dword;
      if (victim_adv)
        victim_r <= (victim_r == lg_entries_lp'(entries_p - 1)) ? '0
                                                                : victim_r + lg_entries_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_r <= '0;
      tag_r   <= '0;
      data_r  <= '0;
    end else begin
      if (bus.flush_i) begin
        valid_r <= '0;
      end else if (fill_we) begin
        valid_r[fill_idx] <= 1'b1;
      end
      if (fill_we) begin
        tag_r[fill_idx]  <= miss_addr_r;
        data_r[fill_idx] <= bus.mem_data_i;
      end
    end
  end

`ifdef BP_BE_PTW_PTE_RESPONDER_PERF_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      if (s2_hit && (hit_cnt_r != 32'hFFFF_FFFF))   hit_cnt_r  <= hit_cnt_r + 32'd1;
      if (s2_miss && (miss_cnt_r != 32'hFFFF_FFFF)) miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;
`endif

endmodule

// File: doc/bp_be_ptw_pte_responder.md
Name: bp_be_ptw_pte_responder

Overview:
- Responder for the page-table-walker d-cache load port: accepts PTE load packets, takes the physical tag one cycle later, and returns the 64-bit PTE from a small fully-associative PTE buffer.
- On a buffer miss, returns not-valid, which makes the walker replay the load; the block then fetches the dword from a backing-memory port and fills the buffer.
- Sits between bp_be_ptw and the L2/memory side in PTW-isolation and FPGA-lite configurations, where the walker does not share the main D$.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p and ptag_width_p.
- entries_p, 4, number of PTE buffer entries; must be at least 1.
- Derived: lg_entries_lp = `BSG_SAFE_CLOG2(entries_p); dword_addr_width_lp = paddr_width_p-3.

Ports:
- clk_i in 1: clock.
- reset_n_i in 1: asynchronous active-low reset.
- dcache_v_i in 1: load packet valid; walker asserts it only while dcache_rdy_o=1.
- dcache_pkt_i in $bits(bp_be_dcache_pkt_s): opcode, page_offset[11:0], data, rd_addr.
- dcache_rdy_o out 1: can accept a packet this cycle.
- dcache_ptag_i in ptag_width_p: physical tag for the packet accepted last cycle.
- dcache_ptag_v_i in 1: ptag valid.
- dcache_v_o out 1: PTE data valid; same cycle as the ptag.
- dcache_data_o out dpath_width_gp: PTE, zero-extended to dpath width.
- flush_i in 1: invalidate all entries (sfence.vma / satp write).
- mem_v_o out 1: backing-memory read request valid.
- mem_addr_o out paddr_width_p: dword-aligned read address.
- mem_ready_i in 1: request accepted.
- mem_v_i in 1: read data valid.
- mem_data_i in 64: read data.

Behaviour:
- Reset (async assert, sync deassert, flop state async-cleared):
  - All entry valid bits 0; victim pointer 0; state eReady; s1_v_r 0.
  - Outputs: dcache_rdy_o=0 while reset is asserted; dcache_v_o=0, mem_v_o=0, dcache_data_o=0, mem_addr_o=0.
- Stage 1 (accept): occurs when dcache_v_i & dcache_rdy_o & opcode==e_dcache_op_ld. Latch page_offset and set s1_v_r. A packet with any other opcode is dropped silently: no s1_v_r, no response.
- dcache_rdy_o = (state==eReady) & ~s1_v_r & ~flush_i.
- Stage 2 (cycle after accept, s1_v_r=1):
  - addr = {dcache_ptag_i, page_offset}; compare addr[paddr-1:3] against all valid tags.
  - Hit (and no flush_i): dcache_v_o=1, dcache_data_o = entry data, combinationally in the same cycle.
  - Miss: dcache_v_o=0, latch the dword address, state -> eMissReq.
  - dcache_ptag_v_i=0 in stage 2: request dropped, dcache_v_o=0, no fill.
  - s1_v_r clears unconditionally at the end of stage 2.
- State machine:
  - eReady: no pending miss; moves to eMissReq on a stage-2 miss.
  - eMissReq: mem_v_o=1, mem_addr_o = {dword_addr, 3'b0}. On mem_ready_i -> eMissWait; mem_v_o drops the next cycle.
  - eMissWait: wait for mem_v_i, then write the entry and return to eReady. The fill is visible to a lookup in the following cycle.
  - Only one outstanding miss; dcache_rdy_o stays 0 throughout eMissReq and eMissWait.
- Replacement: lowest-index invalid entry; if all are valid, the round-robin victim pointer, which increments modulo entries_p after each fill into a full buffer.
- Same-address refill: if the address is already present (possible only after a flush race), overwrite that entry instead of allocating a second one.
- Flush:
  - flush_i clears all valid bits on the next edge and forces dcache_v_o=0 in that cycle.
  - A flush during eMissReq or eMissWait sets a poison flag. The pending fill still completes the memory handshake, but its data is not written.
  - Flush and fill in the same cycle: flush wins, nothing is written.
  - Poison clears on return to eReady.
- No memory-side timeout; mem_v_i arriving outside eMissWait is ignored.

Optional Feature:
- Macro: BP_BE_PTW_PTE_RESPONDER_PERF_EN.
- When defined:
  - Adds output ports hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments on each stage-2 hit; miss_cnt_o increments on each stage-2 miss.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are not cleared by flush_i.
- When undefined: no counter ports or logic are present.

Test Plan:
- Cold miss: send page_offset 12'h010 with ptag 28'h0008_0. Required: dcache_v_o=0, mem_v_o=1 with mem_addr_o=0x8_0010. Return mem_data 64'h0000_0000_2000_00CF; replay the load. Required: dcache_v_o=1 with that data, exactly one mem request.
- Fill all entries_p=4 buffer entries with addresses A0–A3, then miss on A4. Required: A4 replaces entry 0 (pointer 0 -> 1); a subsequent A0 lookup misses and A1 hits.
- flush_i asserted while in eMissWait, then mem_v_i returns. Required: no entry written; the replay misses again and issues a second mem request.
- Accept a load and hold dcache_ptag_v_i=0 in stage 2. Required: dcache_v_o=0, no mem_v_o, dcache_rdy_o=1 on the following cycle.
- Packet with opcode e_dcache_op_sd. Required: ignored, no dcache_v_o, no state change.
- Assert reset_n_i=0 mid-eMissReq, asynchronously. Required: mem_v_o drops immediately, all entries invalid, dcache_rdy_o=1 on the first cycle after deassertion; with PERF_EN, both counters read 0.
